mul_scheduler: RTL and testbench
================================

Name: mul_scheduler

Overview:
- Shares one Booth radix-4 multiplier between NREQ requesters and sequences its operand-loading protocol.
- Grants requests round-robin and presents the multiplicand, then the multiplier, on the shared 8-bit operand bus.
- Waits for the multiplier's done, then returns the signed 16-bit product with the requester id over a valid/ready response channel.
- Sits between client blocks and the multiplier instance and is the only driver of the multiplier's bgn/inbus.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 64, maximum cycles in WAIT before an error response (>= 16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  8*NREQ  multiplicands, requester i at [8i+7:8i], two's complement.
- req_b  in  8*NREQ  multipliers, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester served.
- rsp_prod  out  16  signed product; 0 when rsp_err=1.
- rsp_err  out  1  timeout flag.
- mul_bgn  out  1  start pulse to the multiplier.
- mul_inbus  out  8  operand bus to the multiplier.
- mul_done  in  1  multiplier done (level).
- mul_outbus  in  17  multiplier result; the product is [15:0].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_prod=0, rsp_err=0, mul_bgn=0, mul_inbus=0, busy=0, grant pointer=NREQ-1, timer=0, done_q=0.
- Reset asserted in any state aborts the operation with no response, and the pointer returns to NREQ-1.
- States: IDLE -> LOAD_M -> LOAD_Q -> WAIT -> RESP -> IDLE.
- IDLE, grant:
  - If any req_valid is set, the winner is the first set bit searched from pointer+1 upward, wrapping.
  - req_ready[winner]=1 combinationally in that cycle only.
  - On the clock edge, latch a, b and the id, set pointer=winner, and go to LOAD_M.
  - With no valid request, stay in IDLE.
- LOAD_M: exactly 1 cycle; mul_bgn=1, mul_inbus=latched a.
- LOAD_Q: exactly 1 cycle; mul_bgn=0, mul_inbus=latched b.
- WAIT:
  - mul_inbus=0 and the timer increments each cycle.
  - On a rising edge of mul_done (mul_done=1 and done_q=0): capture mul_outbus[15:0] into rsp_prod, rsp_err=0, go to RESP.
  - If the timer reaches TIMEOUT-1 without an edge: rsp_prod=0, rsp_err=1, go to RESP.
  - An edge and the timeout in the same cycle resolve as success.
- done_q: registers mul_done every cycle in all states. A done level held over from a previous operation is therefore never taken as completion; only a fresh 0->1 transition observed in WAIT counts.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_prod and rsp_err held stable until rsp_ready=1.
  - When rsp_ready=1, go to IDLE.
  - No new grant is issued while in RESP.
- Latency: with the multiplier asserting done D cycles after the LOAD_Q cycle, rsp_valid rises D+3 cycles after the grant cycle.
- Outputs are decoded from the state and data registers only; apart from req_ready, no output depends combinationally on an input.
- Minimum IDLE residency is 1 cycle between operations, which guarantees mul_bgn=0 for at least 3 cycles between start pulses.

Decomposition:
- Package mul_sched_pkg holds:
  - the state enum (IDLE, LOAD_M, LOAD_Q, WAIT, RESP);
  - OPW=8, PRODW=16, MULOUTW=17;
  - the timer width derived from TIMEOUT.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and winner index;
  - purely combinational; the pointer register stays in mul_scheduler.

Test Plan:
- Single request: req0 a=0x07, b=0x03; model multiplier raises done 12 cycles after LOAD_Q with outbus=0x00015 -> mul_bgn pulse 1 cycle with inbus=0x07, then inbus=0x03; rsp_prod=0x0015, rsp_id=0, rsp_err=0, rsp_valid 15 cycles after grant.
- Signed operands: a=0xF9 (-7), b=0x03; model returns 0x1FFEB -> rsp_prod=0xFFEB.
- Round-robin: req0 and req1 held valid continuously, rsp_ready=1 -> grant order 0,1,0,1; each req_ready is a 1-cycle one-hot pulse; first grant goes to 0 after reset.
- Backpressure: rsp_ready=0 for 5 cycles with req1 valid -> rsp_valid, rsp_prod and rsp_id stable; req_ready stays 0; mul_bgn stays 0 until the response is accepted.
- Timeout and stale done: model holds mul_done=1 from before the grant and never toggles it, TIMEOUT=64 -> no capture; rsp_err=1, rsp_prod=0 after exactly 64 WAIT cycles.
- Reset mid-WAIT: assert rst asynchronously between clock edges -> all outputs zero immediately, no response issued; a subsequent req1 is granted normally with pointer starting from NREQ-1.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared widths, state encoding and timer sizing for mul_scheduler
package mul_sched_pkg;
    localparam int OPW = 8;
    localparam int PRODW = 16;
    localparam int MULOUTW = 17;
    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, WAIT, RESP} state_e;
    function automatic int timer_w(input int timeout);
        return $clog2(timeout);
    endfunction
endpackage

// File: rtl/mul_scheduler_if.sv
// mul_scheduler_if: request, response and multiplier-side buses of the scheduler
interface mul_scheduler_if
    import mul_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW = 1
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [OPW*NREQ-1:0] req_a;
    logic [OPW*NREQ-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [PRODW-1:0] rsp_prod;
    logic rsp_err;
    logic mul_bgn;
    logic [OPW-1:0] mul_inbus;
    logic mul_done;
    logic [MULOUTW-1:0] mul_outbus;
    modport master (
        input req_valid, req_a, req_b, rsp_ready, mul_done, mul_outbus,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_bgn, mul_inbus
    );
    modport slave (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_outbus,
        input req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_bgn, mul_inbus
    );
endinterface

// File: rtl/mul_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1 with wrap
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);
    logic [IDW-1:0] c;
    logic hit;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit = 1'b0;
        c = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = IDW'((int'(ptr_i) + k) % NREQ);
            if (en_i && !hit && req_i[c]) begin
                gnt_o[c] = 1'b1;
                idx_o = c;
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin sharing of one Booth multiplier; loads a then b,
// waits for a fresh done edge (or timeout) and returns the product with the requester id.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW = 1,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    mul_scheduler_if.master bus,
    output logic busy
);
    localparam int TW = timer_w(TIMEOUT);
    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_LOAD_M = LOAD_M;
    localparam logic [2:0] S_LOAD_Q = LOAD_Q;
    localparam logic [2:0] S_WAIT = WAIT;
    localparam logic [2:0] S_RESP = RESP;

    logic [2:0] state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;
    logic [PRODW-1:0] prod_q, prod_d;
    logic err_q, err_d, done_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [NREQ-1:0] gnt;
    logic done_rise, timeout;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i(bus.req_valid),
        .ptr_i(ptr_q),
        .en_i(state_q == S_IDLE && !rst),
        .gnt_o(gnt),
        .idx_o(win)
    );

    // A done level left over from an earlier operation must not count as completion
    assign done_rise = bus.mul_done && !done_q;
    assign timeout = timer_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        id_d = id_q;
        a_d = a_q;
        b_d = b_q;
        prod_d = prod_q;
        err_d = err_q;
        timer_d = state_q == S_WAIT ? timer_q + 1'b1 : '0;
        case (state_q)
            S_IDLE: if (|gnt) begin
                state_d = S_LOAD_M;
                ptr_d = win;
                id_d = win;
                a_d = bus.req_a[OPW*win +: OPW];
                b_d = bus.req_b[OPW*win +: OPW];
            end
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: state_d = S_WAIT;
            S_WAIT: if (done_rise || timeout) begin
                state_d = S_RESP;
                prod_d = done_rise ? bus.mul_outbus[PRODW-1:0] : '0;
                err_d = !done_rise;
            end
            S_RESP: state_d = bus.rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q <= IDW'(NREQ - 1);
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            prod_q <= '0;
            err_q <= 1'b0;
            timer_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            id_q <= id_d;
            a_q <= a_d;
            b_q <= b_d;
            prod_q <= prod_d;
            err_q <= err_d;
            timer_q <= timer_d;
            done_q <= bus.mul_done;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = state_q == S_RESP;
    assign bus.rsp_id = id_q;
    assign bus.rsp_prod = prod_q;
    assign bus.rsp_err = err_q;
    assign bus.mul_bgn = state_q == S_LOAD_M;
    assign bus.mul_inbus = state_q == S_LOAD_M ? a_q : state_q == S_LOAD_Q ? b_q : '0;
    assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: table vectors, multi-cycle corner sequences and random traffic
// checked against a round-robin / signed-product reference.
module tb_mul_scheduler;
    localparam int NREQ = 2;
    localparam int IDW = 1;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [8*NREQ-1:0] a;
        logic [8*NREQ-1:0] b;
        int d;
        int hold;
        bit stale;
        int id;
        logic [15:0] prod;
        bit err;
        int lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int checks = 0;
    int failures = 0;
    int mdl_d;
    bit mdl_stale;
    int ptr_m;

    mul_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: takes a on the bgn cycle, b on the next, raises done mdl_d cycles later
    logic [7:0] ma, mb;
    int cnt;
    bit ldq;
    always @(negedge clk) begin
        logic signed [16:0] p;
        if (rst) begin
            cnt = 0;
            ldq = 0;
            bus.mul_done = 1'b0;
            bus.mul_outbus = '0;
        end else begin
            if (ldq) begin
                mb = bus.mul_inbus;
                ldq = 0;
                cnt = mdl_d;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    p = $signed(ma) * $signed(mb);
                    bus.mul_outbus = p;
                    bus.mul_done = 1'b1;
                end
            end
            if (bus.mul_bgn) begin
                ma = bus.mul_inbus;
                ldq = 1;
                bus.mul_done = 1'b0;
            end
            if (mdl_stale) bus.mul_done = 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++)
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic run_op(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] a, b,
                          input int d, hold, input bit stale, input int id,
                          input logic [15:0] prod, input bit err, input int lat);
        logic [8*NREQ-1:0] sa, sb;
        int n;
        sa = a >> (8 * id);
        sb = b >> (8 * id);
        mdl_d = d;
        mdl_stale = stale;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = mask;
        bus.rsp_ready = hold == 0;
        #1;
        chk("grant_ready", bus.req_ready, 1 << id);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("loadm_bgn", bus.mul_bgn, 1);
        chk("loadm_inbus", bus.mul_inbus, sa[7:0]);
        chk("loadm_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("loadq_bgn", bus.mul_bgn, 0);
        chk("loadq_inbus", bus.mul_inbus, sb[7:0]);
        n = 2;
        while (!bus.rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", n, lat);
        chk("rsp_prod", bus.rsp_prod, prod);
        chk("rsp_err", bus.rsp_err, err);
        chk("rsp_id", bus.rsp_id, id);
        if (hold > 0) begin
            bus.req_valid = '1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_valid", bus.rsp_valid, 1);
                chk("bp_prod", bus.rsp_prod, prod);
                chk("bp_id", bus.rsp_id, id);
                chk("bp_ready", bus.req_ready, 0);
                chk("bp_bgn", bus.mul_bgn, 0);
            end
            bus.req_valid = '0;
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("rsp_drop", bus.rsp_valid, 0);
        chk("back_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = NREQ - 1;
    endtask

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ng, cyc, w, seen;
        logic [NREQ-1:0] cur, prev, m;
        logic [8*NREQ-1:0] ra, rb, sa, sb;
        logic signed [15:0] ep;
        tbl[0] = '{2'b01, 16'h0007, 16'h0003, 12, 0, 1'b0, 0, 16'h0015, 1'b0, 15};
        tbl[1] = '{2'b01, 16'h00F9, 16'h0003, 5, 0, 1'b0, 0, 16'hFFEB, 1'b0, 8};
        tbl[2] = '{2'b11, 16'h807F, 16'h807F, 3, 0, 1'b0, 1, 16'h4000, 1'b0, 6};
        tbl[3] = '{2'b11, 16'h0080, 16'h007F, 1, 0, 1'b0, 0, 16'hC080, 1'b0, 4};
        tbl[4] = '{2'b10, 16'hFF00, 16'hFF00, 7, 5, 1'b0, 1, 16'h0001, 1'b0, 10};
        tbl[5] = '{2'b01, 16'h0000, 16'h0055, 2, 0, 1'b0, 0, 16'h0000, 1'b0, 5};
        tbl[6] = '{2'b10, 16'h1200, 16'h3400, 1, 0, 1'b1, 1, 16'h0000, 1'b1, 67};
        tbl[7] = '{2'b11, 16'h05FD, 16'h0604, 9, 2, 1'b0, 0, 16'hFFF4, 1'b0, 12};
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        mdl_d = 1;
        mdl_stale = 0;
        ptr_m = NREQ - 1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_prod", bus.rsp_prod, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_bgn", bus.mul_bgn, 0);
        chk("rst_inbus", bus.mul_inbus, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        do_reset();

        foreach (tbl[i]) begin
            run_op(tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].hold, tbl[i].stale,
                   tbl[i].id, tbl[i].prod, tbl[i].err, tbl[i].lat);
            mdl_stale = 0;
        end

        // Two requesters held valid continuously: grants must alternate starting at 0
        do_reset();
        mdl_d = 4;
        bus.req_a = 16'h0305;
        bus.req_b = 16'h0204;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        ng = 0;
        cyc = 0;
        prev = '0;
        while (ng < 4 && cyc < 400) begin
            #1;
            cur = bus.req_ready;
            if (cur != 0) begin
                chk("rr_onehot", $onehot(cur), 1);
                chk("rr_pulse", prev, 0);
                w = cur[1] ? 1 : 0;
                chk("rr_order", w, ng % 2);
                ng++;
            end
            prev = cur;
            @(posedge clk);
            cyc++;
        end
        #1;
        bus.req_valid = '0;
        chk("rr_grants", ng, 4);
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rr_drain", busy, 0);

        // Asynchronous reset while waiting on the multiplier
        bus.req_a = 16'h0011;
        bus.req_b = 16'h0022;
        mdl_d = 30;
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bgn", bus.mul_bgn, 0);
        chk("arst_inbus", bus.mul_inbus, 0);
        chk("arst_prod", bus.rsp_prod, 0);
        chk("arst_id", bus.rsp_id, 0);
        chk("arst_err", bus.rsp_err, 0);
        chk("arst_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = NREQ - 1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || busy) seen = 1;
        end
        chk("no_rsp_after_rst", seen, 0);
        run_op(2'b11, 16'h090A, 16'h02F6, 6, 0, 1'b0, 0, 16'hFF9C, 1'b0, 9);
        run_op(2'b10, 16'h090A, 16'h02F6, 3, 0, 1'b0, 1, 16'h0012, 1'b0, 6);
        ptr_m = 1;

        for (int i = 0; i < 40; i++) begin
            int d, hold;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            d = $urandom_range(1, 15);
            hold = $urandom_range(0, 3);
            w = rr_pick(ptr_m, m);
            sa = ra >> (8 * w);
            sb = rb >> (8 * w);
            ep = $signed(sa[7:0]) * $signed(sb[7:0]);
            run_op(m, ra, rb, d, hold, 1'b0, w, ep, 1'b0, d + 3);
            ptr_m = w;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
